// File: rtl/machine_csr_file_pkg.sv
// Shared constants and helpers for the machine-mode CSR file.
package machine_csr_file_pkg;

  // CSR addresses
  localparam logic [11:0] CSR_MSTATUS   = 12'h300;
  localparam logic [11:0] CSR_MISA      = 12'h301;
  localparam logic [11:0] CSR_MIE       = 12'h304;
  localparam logic [11:0] CSR_MTVEC     = 12'h305;
  localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
  localparam logic [11:0] CSR_MEPC      = 12'h341;
  localparam logic [11:0] CSR_MCAUSE    = 12'h342;
  localparam logic [11:0] CSR_MTVAL     = 12'h343;
  localparam logic [11:0] CSR_MIP       = 12'h344;
  localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
  localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
  localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
  localparam logic [11:0] CSR_CYCLE     = 12'hC00;
  localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
  localparam logic [11:0] CSR_INSTRET   = 12'hC02;
  localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
  localparam logic [11:0] CSR_MHARTID   = 12'hF14;

  // funct3 encodings of CSR instructions
  typedef enum logic [2:0] {
    CSR_OP_NONE = 3'b000,
    CSR_OP_RW   = 3'b001,
    CSR_OP_RS   = 3'b010,
    CSR_OP_RC   = 3'b011,
    CSR_OP_RWI  = 3'b101,
    CSR_OP_RSI  = 3'b110,
    CSR_OP_RCI  = 3'b111
  } csr_op_e;

  localparam logic [31:0] MISA_VALUE = 32'h4000_0100;

  // Bit positions inside mstatus / mie / mip
  localparam int MSTATUS_MIE_BIT  = 3;
  localparam int MSTATUS_MPIE_BIT = 7;
  localparam int MIE_MEIE_BIT     = 11;
  localparam int MIE_MTIE_BIT     = 7;
  localparam int MIE_MSIE_BIT     = 3;

  // Set/clear ops with a zero operand must not write (no side effects).
  function automatic logic csr_op_writes(logic [2:0] op, logic [31:0] wdata);
    case (op)
      CSR_OP_RW, CSR_OP_RWI:                         return 1'b1;
      CSR_OP_RS, CSR_OP_RC, CSR_OP_RSI, CSR_OP_RCI:  return (wdata != 32'h0);
      default:                                       return 1'b0;
    endcase
  endfunction

  // Immediate forms share op[1:0] with register forms; wdata is pre-muxed.
  function automatic logic [31:0] csr_alu(logic [2:0] op, logic [31:0] old,
                                          logic [31:0] wdata);
    case (op[1:0])
      2'b01:   return wdata;
      2'b10:   return old | wdata;
      2'b11:   return old & ~wdata;
      default: return old;
    endcase
  endfunction

endpackage

// File: rtl/machine_csr_file_if.sv
// Pipeline <-> CSR file signal bundle. master = pipeline, slave = CSR file.
interface machine_csr_file_if;
  logic        eirq_in, tirq_in, sirq_in;
  logic [11:0] csr_addr_in;
  logic [2:0]  csr_op_in;
  logic        csr_wr_en_in;
  logic [31:0] csr_wdata_in;
  logic [31:0] pc_in;
  logic [31:0] iadder_in;
  logic        i_or_e_in;
  logic [3:0]  cause_in;
  logic        set_cause_in, set_epc_in;
  logic        mie_clear_in, mie_set_in;
  logic        instret_inc_in;
  logic        misaligned_exception_in;
  logic [31:0] csr_rdata_out;
  logic        mie_out, meie_out, mtie_out, msie_out;
  logic        meip_out, mtip_out, msip_out;
  logic [31:0] epc_out;
  logic [31:0] trap_address_out;

  modport master (
    output eirq_in, tirq_in, sirq_in, csr_addr_in, csr_op_in, csr_wr_en_in,
           csr_wdata_in, pc_in, iadder_in, i_or_e_in, cause_in, set_cause_in,
           set_epc_in, mie_clear_in, mie_set_in, instret_inc_in,
           misaligned_exception_in,
    input  csr_rdata_out, mie_out, meie_out, mtie_out, msie_out, meip_out,
           mtip_out, msip_out, epc_out, trap_address_out
  );

  modport slave (
    input  eirq_in, tirq_in, sirq_in, csr_addr_in, csr_op_in, csr_wr_en_in,
           csr_wdata_in, pc_in, iadder_in, i_or_e_in, cause_in, set_cause_in,
           set_epc_in, mie_clear_in, mie_set_in, instret_inc_in,
           misaligned_exception_in,
    output csr_rdata_out, mie_out, meie_out, mtie_out, msie_out, meip_out,
           mtip_out, msip_out, epc_out, trap_address_out
  );
endinterface

// File: rtl/csr_counter_64.sv
// 64-bit performance counter; a software write to either half replaces the
// increment for that cycle, so the written value is what software reads back.
module csr_counter_64 (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        inc,
  input  logic        wr_lo,
  input  logic        wr_hi,
  input  logic [31:0] wdata,
  output logic [63:0] count
);

  // Write has priority over increment; full 64-bit add carries lo->hi.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in)     count <= 64'h0;
    else if (wr_lo) count[31:0]  <= wdata;
    else if (wr_hi) count[63:32] <= wdata;
    else if (inc)   count <= count + 64'h1;
  end

endmodule

// File: rtl/machine_csr_file.sv
// Machine-mode CSR file: status, interrupt enable/pending, trap state,
// trap vector, scratch and 64-bit cycle/instret counters.
module machine_csr_file
  import machine_csr_file_pkg::*;
#(
  parameter logic [31:0] RESET_MTVEC = 32'h0000_0000,
  parameter logic [31:0] MHARTID     = 32'h0000_0000
) (
  input logic               clk_in,
  input logic               rst_in,
  machine_csr_file_if.slave bus
);

  logic        mst_mie, mst_mpie;
  logic        meie, mtie, msie;
  logic        meip, mtip, msip;
  logic [31:0] mtvec, mscratch, mepc, mcause, mtval;
  logic [63:0] mcycle, minstret;
  logic [31:0] rdata, wval, mstatus_rd, mie_rd, mip_rd, tvec_base;
  logic        sw_we;

  // mtvec[1] is never stored as 1 so mode decode only sees bit 0.
  localparam logic [31:0] MTVEC_INIT = RESET_MTVEC & ~32'h2;

  // Assemble sparse registers into their architectural layouts.
  always_comb begin
    mstatus_rd = 32'h0;
    mstatus_rd[12:11] = 2'b11;
    mstatus_rd[MSTATUS_MIE_BIT]  = mst_mie;
    mstatus_rd[MSTATUS_MPIE_BIT] = mst_mpie;
    mie_rd = 32'h0;
    mie_rd[MIE_MEIE_BIT] = meie;
    mie_rd[MIE_MTIE_BIT] = mtie;
    mie_rd[MIE_MSIE_BIT] = msie;
    mip_rd = 32'h0;
    mip_rd[MIE_MEIE_BIT] = meip;
    mip_rd[MIE_MTIE_BIT] = mtip;
    mip_rd[MIE_MSIE_BIT] = msip;
  end

  // Combinational read mux; unimplemented addresses read zero.
  always_comb begin
    rdata = 32'h0;
    case (bus.csr_addr_in)
      CSR_MSTATUS:                 rdata = mstatus_rd;
      CSR_MISA:                    rdata = MISA_VALUE;
      CSR_MIE:                     rdata = mie_rd;
      CSR_MTVEC:                   rdata = mtvec;
      CSR_MSCRATCH:                rdata = mscratch;
      CSR_MEPC:                    rdata = mepc;
      CSR_MCAUSE:                  rdata = mcause;
      CSR_MTVAL:                   rdata = mtval;
      CSR_MIP:                     rdata = mip_rd;
      CSR_MCYCLE,   CSR_CYCLE:     rdata = mcycle[31:0];
      CSR_MCYCLEH,  CSR_CYCLEH:    rdata = mcycle[63:32];
      CSR_MINSTRET, CSR_INSTRET:   rdata = minstret[31:0];
      CSR_MINSTRETH, CSR_INSTRETH: rdata = minstret[63:32];
      CSR_MHARTID:                 rdata = MHARTID;
      default:                     rdata = 32'h0;
    endcase
  end

  assign sw_we = bus.csr_wr_en_in && csr_op_writes(bus.csr_op_in, bus.csr_wdata_in);
  assign wval  = csr_alu(bus.csr_op_in, rdata, bus.csr_wdata_in);

  function automatic logic hit(logic [11:0] a);
    return sw_we && (bus.csr_addr_in == a);
  endfunction

  // mstatus: trap entry beats mret, both beat a software write.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      mst_mie  <= 1'b0;
      mst_mpie <= 1'b0;
    end else if (bus.mie_clear_in) begin
      mst_mpie <= mst_mie;
      mst_mie  <= 1'b0;
    end else if (bus.mie_set_in) begin
      mst_mie  <= mst_mpie;
      mst_mpie <= 1'b1;
    end else if (hit(CSR_MSTATUS)) begin
      mst_mie  <= wval[MSTATUS_MIE_BIT];
      mst_mpie <= wval[MSTATUS_MPIE_BIT];
    end
  end

  // mie enables: only the three machine-level bits exist.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      {meie, mtie, msie} <= 3'b000;
    end else if (hit(CSR_MIE)) begin
      meie <= wval[MIE_MEIE_BIT];
      mtie <= wval[MIE_MTIE_BIT];
      msie <= wval[MIE_MSIE_BIT];
    end
  end

  // mip follows the interrupt lines with one cycle of latency.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) {meip, mtip, msip} <= 3'b000;
    else        {meip, mtip, msip} <= {bus.eirq_in, bus.tirq_in, bus.sirq_in};
  end

  // mtvec and mscratch are software-only.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      mtvec    <= MTVEC_INIT;
      mscratch <= 32'h0;
    end else begin
      if (hit(CSR_MTVEC))    mtvec    <= wval & ~32'h2;
      if (hit(CSR_MSCRATCH)) mscratch <= wval;
    end
  end

  // Trap state: hardware capture wins over a same-cycle software write.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      mepc   <= 32'h0;
      mcause <= 32'h0;
      mtval  <= 32'h0;
    end else begin
      if (bus.set_epc_in)      mepc <= bus.pc_in & ~32'h3;
      else if (hit(CSR_MEPC))  mepc <= wval & ~32'h3;
      if (bus.set_cause_in) begin
        mcause <= {bus.i_or_e_in, 27'h0, bus.cause_in};
        mtval  <= bus.misaligned_exception_in ? bus.iadder_in : 32'h0;
      end else begin
        if (hit(CSR_MCAUSE)) mcause <= wval;
        if (hit(CSR_MTVAL))  mtval  <= wval;
      end
    end
  end

  csr_counter_64 u_mcycle (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .inc    (1'b1),
    .wr_lo  (hit(CSR_MCYCLE)),
    .wr_hi  (hit(CSR_MCYCLEH)),
    .wdata  (wval),
    .count  (mcycle)
  );

  csr_counter_64 u_minstret (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .inc    (bus.instret_inc_in),
    .wr_lo  (hit(CSR_MINSTRET)),
    .wr_hi  (hit(CSR_MINSTRETH)),
    .wdata  (wval),
    .count  (minstret)
  );

  // Vectored mode only offsets interrupts; exceptions go to the base.
  assign tvec_base = {mtvec[31:2], 2'b00};
  assign bus.trap_address_out = (mtvec[0] && bus.i_or_e_in)
                              ? tvec_base + {26'h0, bus.cause_in, 2'b00}
                              : tvec_base;

  assign bus.csr_rdata_out = rdata;
  assign bus.mie_out  = mst_mie;
  assign bus.meie_out = meie;
  assign bus.mtie_out = mtie;
  assign bus.msie_out = msie;
  assign bus.meip_out = meip;
  assign bus.mtip_out = mtip;
  assign bus.msip_out = msip;
  assign bus.epc_out  = mepc;

endmodule

// File: tb/tb_machine_csr_file.sv
// Directed bench for machine_csr_file: table of single-write vectors plus
// hand-written sequences for traps, interrupts, counters and reset.
module tb_machine_csr_file;

  localparam logic [31:0] T_MTVEC = 32'h8000_0000;
  localparam logic [31:0] T_HART  = 32'h0000_0005;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  machine_csr_file_if bus();

  machine_csr_file #(.RESET_MTVEC(T_MTVEC), .MHARTID(T_HART)) dut (
    .clk_in (clk),
    .rst_in (rst),
    .bus    (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t vt[20];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic rd(input logic [11:0] a, output logic [31:0] d);
    bus.csr_wr_en_in = 1'b0;
    bus.csr_addr_in  = a;
    #1;
    d = bus.csr_rdata_out;
  endtask

  task automatic rdchk(input string name, input logic [11:0] a, input logic [31:0] exp);
    logic [31:0] d;
    rd(a, d);
    chk(name, d, exp);
  endtask

  // One write, committed on the next rising edge; returns at edge + 1.
  task automatic wr(input logic [2:0] op, input logic [11:0] a, input logic [31:0] d);
    bus.csr_op_in    = op;
    bus.csr_addr_in  = a;
    bus.csr_wdata_in = d;
    bus.csr_wr_en_in = 1'b1;
    @(posedge clk); #1;
    bus.csr_wr_en_in = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  initial begin
    bus.eirq_in = 0; bus.tirq_in = 0; bus.sirq_in = 0;
    bus.csr_addr_in = 0; bus.csr_op_in = 0; bus.csr_wr_en_in = 0;
    bus.csr_wdata_in = 0; bus.pc_in = 0; bus.iadder_in = 0;
    bus.i_or_e_in = 0; bus.cause_in = 0; bus.set_cause_in = 0;
    bus.set_epc_in = 0; bus.mie_clear_in = 0; bus.mie_set_in = 0;
    bus.instret_inc_in = 0; bus.misaligned_exception_in = 0;

    vt[0]  = '{3'b001, 12'h340, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vt[1]  = '{3'b011, 12'h340, 32'h0000_00FF, 32'hDEAD_BE00};
    vt[2]  = '{3'b010, 12'h340, 32'h0000_0000, 32'hDEAD_BE00};
    vt[3]  = '{3'b110, 12'h340, 32'h0000_000F, 32'hDEAD_BE0F};
    vt[4]  = '{3'b111, 12'h340, 32'h0000_000F, 32'hDEAD_BE00};
    vt[5]  = '{3'b101, 12'h340, 32'h0000_001F, 32'h0000_001F};
    vt[6]  = '{3'b000, 12'h340, 32'h1234_5678, 32'h0000_001F};
    vt[7]  = '{3'b100, 12'h340, 32'h1234_5678, 32'h0000_001F};
    vt[8]  = '{3'b001, 12'h304, 32'hFFFF_FFFF, 32'h0000_0888};
    vt[9]  = '{3'b011, 12'h304, 32'h0000_0080, 32'h0000_0808};
    vt[10] = '{3'b001, 12'h300, 32'hFFFF_FFFF, 32'h0000_1888};
    vt[11] = '{3'b001, 12'h300, 32'h0000_0000, 32'h0000_1800};
    vt[12] = '{3'b001, 12'h301, 32'h0000_0000, 32'h4000_0100};
    vt[13] = '{3'b001, 12'hF14, 32'hFFFF_FFFF, 32'h0000_0005};
    vt[14] = '{3'b001, 12'h341, 32'h0000_0123, 32'h0000_0120};
    vt[15] = '{3'b001, 12'h305, 32'h0000_1003, 32'h0000_1001};
    vt[16] = '{3'b001, 12'h7C0, 32'hFFFF_FFFF, 32'h0000_0000};
    vt[17] = '{3'b001, 12'h344, 32'hFFFF_FFFF, 32'h0000_0000};
    vt[18] = '{3'b001, 12'h342, 32'h8000_0007, 32'h8000_0007};
    vt[19] = '{3'b001, 12'h343, 32'hAAAA_5555, 32'hAAAA_5555};

    // Reset state, observed while reset is still held.
    repeat (2) @(negedge clk);
    chk("rst_trap_addr", bus.trap_address_out, T_MTVEC);
    chk("rst_epc", bus.epc_out, 32'h0);
    chk("rst_mie_out", {31'h0, bus.mie_out}, 32'h0);
    rdchk("rst_mtvec", 12'h305, T_MTVEC);
    rdchk("rst_mhartid", 12'hF14, T_HART);
    rdchk("rst_mstatus", 12'h300, 32'h0000_1800);
    rdchk("rst_mscratch", 12'h340, 32'h0);
    @(negedge clk); rst = 1'b0;
    tick();

    // Table of single writes, each read back after commit.
    for (int i = 0; i < 20; i++) begin
      wr(vt[i].op, vt[i].addr, vt[i].wdata);
      rdchk($sformatf("vec%0d_%h", i, vt[i].addr), vt[i].addr, vt[i].exp);
    end
    chk("meie_out", {29'h0, bus.meie_out, bus.mtie_out, bus.msie_out}, 32'h5);

    // Interrupt lines reach mip one cycle later.
    bus.eirq_in = 1'b1;
    rdchk("mip_latency", 12'h344, 32'h0);
    tick();
    rdchk("mip_meip", 12'h344, 32'h0000_0800);
    bus.tirq_in = 1'b1; bus.sirq_in = 1'b1;
    tick();
    rdchk("mip_all", 12'h344, 32'h0000_0888);
    chk("mip_outs", {29'h0, bus.meip_out, bus.mtip_out, bus.msip_out}, 32'h7);
    bus.eirq_in = 0; bus.tirq_in = 0; bus.sirq_in = 0;
    tick();

    // Trap entry with misaligned exception, then mret.
    wr(3'b001, 12'h300, 32'h0000_0008);
    rdchk("mstatus_mie1", 12'h300, 32'h0000_1808);
    bus.pc_in = 32'h0000_0103; bus.cause_in = 4'd4; bus.i_or_e_in = 1'b0;
    bus.misaligned_exception_in = 1'b1; bus.iadder_in = 32'h0000_2001;
    bus.set_cause_in = 1; bus.set_epc_in = 1; bus.mie_clear_in = 1;
    tick();
    bus.set_cause_in = 0; bus.set_epc_in = 0; bus.mie_clear_in = 0;
    rdchk("trap_mepc", 12'h341, 32'h0000_0100);
    rdchk("trap_mcause", 12'h342, 32'h0000_0004);
    rdchk("trap_mtval", 12'h343, 32'h0000_2001);
    rdchk("trap_mstatus", 12'h300, 32'h0000_1880);
    chk("trap_epc_out", bus.epc_out, 32'h0000_0100);
    chk("trap_mie_out", {31'h0, bus.mie_out}, 32'h0);
    bus.mie_set_in = 1; tick(); bus.mie_set_in = 0;
    rdchk("mret_mstatus", 12'h300, 32'h0000_1888);
    chk("mret_mie_out", {31'h0, bus.mie_out}, 32'h1);

    // Both clear and set: clear wins.
    bus.mie_clear_in = 1; bus.mie_set_in = 1; tick();
    bus.mie_clear_in = 0; bus.mie_set_in = 0;
    rdchk("clr_wins", 12'h300, 32'h0000_1880);

    // Non-misaligned trap zeroes mtval; interrupt flag lands in mcause[31].
    bus.misaligned_exception_in = 0; bus.i_or_e_in = 1; bus.cause_in = 4'd7;
    bus.set_cause_in = 1; tick(); bus.set_cause_in = 0;
    rdchk("mtval_zero", 12'h343, 32'h0);
    rdchk("mcause_irq", 12'h342, 32'h8000_0007);

    // Trap vector: vectored interrupt vs exception.
    wr(3'b001, 12'h305, 32'h0000_1001);
    bus.i_or_e_in = 1; bus.cause_in = 4'd11; #1;
    chk("tvec_vectored", bus.trap_address_out, 32'h0000_102C);
    bus.i_or_e_in = 0; #1;
    chk("tvec_exc", bus.trap_address_out, 32'h0000_1000);

    // mcycle wrap from all ones.
    wr(3'b001, 12'hB00, 32'hFFFF_FFFF);
    wr(3'b001, 12'hB80, 32'hFFFF_FFFF);
    rdchk("mcycle_written", 12'hB00, 32'hFFFF_FFFF);
    rdchk("mcycleh_written", 12'hB80, 32'hFFFF_FFFF);
    tick();
    rdchk("mcycle_wrap_lo", 12'hB00, 32'h0);
    rdchk("mcycle_wrap_hi", 12'hB80, 32'h0);

    // Carry from low to high word, seen through the user mirror.
    wr(3'b001, 12'hB00, 32'hFFFF_FFFE);
    tick(); tick();
    rdchk("cycle_carry_lo", 12'hC00, 32'h0);
    rdchk("cycle_carry_hi", 12'hC80, 32'h1);

    // minstret counts only on instret_inc; write beats increment.
    wr(3'b001, 12'hB02, 32'h0);
    bus.instret_inc_in = 1; tick(); tick(); tick(); bus.instret_inc_in = 0;
    tick();
    rdchk("instret_3", 12'hC02, 32'h3);
    bus.instret_inc_in = 1;
    wr(3'b001, 12'hB02, 32'h0000_0010);
    bus.instret_inc_in = 0;
    rdchk("instret_wr_wins", 12'hB02, 32'h0000_0010);
    wr(3'b001, 12'hC02, 32'h0000_0099);
    rdchk("instret_ro_mirror", 12'hB02, 32'h0000_0010);

    // Hardware capture beats a same-cycle software write.
    bus.pc_in = 32'h0000_0400; bus.set_epc_in = 1;
    wr(3'b001, 12'h341, 32'h0000_1234);
    bus.set_epc_in = 0;
    rdchk("epc_priority", 12'h341, 32'h0000_0400);

    // Reset asserted mid-cycle abandons the pending write.
    wr(3'b001, 12'h340, 32'h0000_0055);
    bus.csr_op_in = 3'b001; bus.csr_addr_in = 12'h340;
    bus.csr_wdata_in = 32'h0000_00AA; bus.csr_wr_en_in = 1;
    @(negedge clk); rst = 1'b1; #1;
    chk("midrst_mscratch", bus.csr_rdata_out, 32'h0);
    chk("midrst_trap_addr", bus.trap_address_out, T_MTVEC);
    chk("midrst_epc", bus.epc_out, 32'h0);
    @(negedge clk); bus.csr_wr_en_in = 0; rst = 1'b0;
    rdchk("postrst_mscratch", 12'h340, 32'h0);
    rdchk("postrst_mtvec", 12'h305, T_MTVEC);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute time bound so the run always ends.
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete");
    errors++;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/machine_csr_file.md
MACHINE_CSR_FILE -- requirements
Module: machine_csr_file

Interface
REQ-001 SHALL have parameter RESET_MTVEC, default 32'h0000_0000, mtvec value after reset.
REQ-002 SHALL have parameter MHARTID, default 32'h0000_0000, value returned by mhartid.
REQ-003 SHALL have a single clock; reset is asynchronous and active-high; ports named clk_in and rst_in.
REQ-004 SHALL have ports, as name, direction, width and meaning:
- clk_in, in, 1, clock
- rst_in, in, 1, async active-high reset
- eirq_in / tirq_in / sirq_in, in, 1 each, external / timer / software interrupt lines
- csr_addr_in, in, 12, CSR address
- csr_op_in, in, 3, funct3 of CSR instruction
- csr_wr_en_in, in, 1, CSR instruction in stage
- csr_wdata_in, in, 32, rs1 value or zero-extended zimm, already muxed
- pc_in, in, 32, PC of trapping instruction
- iadder_in, in, 32, faulting address for misaligned exceptions
- i_or_e_in, in, 1, 1 = interrupt, 0 = exception
- cause_in, in, 4, trap cause code
- set_cause_in / set_epc_in, in, 1 each, latch mcause(+mtval) / mepc
- mie_clear_in / mie_set_in, in, 1 each, trap entry / mret
- instret_inc_in, in, 1, instruction retired
- misaligned_exception_in, in, 1, current exception is misaligned
- csr_rdata_out, out, 32, read data
- mie_out / meie_out / mtie_out / msie_out, out, 1 each, mstatus.MIE and mie enable bits
- meip_out / mtip_out / msip_out, out, 1 each, mip pending bits
- epc_out, out, 32, mepc
- trap_address_out, out, 32, trap target PC

Function
REQ-005 SHALL drive csr_rdata_out combinationally from csr_addr_in; unimplemented addresses read 0 and ignore writes.
REQ-006 SHALL implement mstatus 300, misa 301 (read-only 32'h4000_0100), mie 304, mtvec 305, mscratch 340, mepc 341, mcause 342, mtval 343, mip 344 (read-only), mcycle/mcycleh B00/B80, minstret/minstreth B02/B82, cycle/cycleh C00/C80 and instret/instreth C02/C82 (read-only mirrors), and mhartid F14.
REQ-007 SHALL decode csr_op_in as 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI; any other value performs no write.
REQ-008 SHALL compute the new value as RW: wdata, RS: old|wdata, RC: old&~wdata, and commit it on the rising edge when csr_wr_en_in=1.
REQ-009 SHALL suppress the write for RS/RC/RSI/RCI when csr_wdata_in=0.
REQ-010 SHALL expose only mstatus bits MIE[3], MPIE[7] and MPP[12:11]; MPP always reads 2'b11; other bits read 0.
REQ-011 SHALL make only mie bits MEIE[11], MTIE[7] and MSIE[3] writable.
REQ-012 SHALL register eirq_in, tirq_in and sirq_in into mip MEIP[11], MTIP[7] and MSIP[3] every cycle, giving one cycle of latency.
REQ-013 SHALL, on set_epc_in, load mepc with {pc_in[31:2],2'b00}; mepc[1:0] always reads 0.
REQ-014 SHALL, on set_cause_in, load mcause with {i_or_e_in,27'b0,cause_in}.
REQ-015 SHALL, on set_cause_in, load mtval with iadder_in when misaligned_exception_in=1, and with 0 otherwise.
REQ-016 SHALL, on mie_clear_in, set MPIE to MIE and MIE to 0; on mie_set_in, set MIE to MPIE and MPIE to 1; if both are asserted, mie_clear_in wins.
REQ-017 SHALL give hardware trap updates priority over a same-cycle software write to the same CSR.
REQ-018 SHALL keep mtvec[1] hardwired to 0; mode = mtvec[0].
REQ-019 SHALL drive trap_address_out as follows: if mode=1 and i_or_e_in=1, {mtvec[31:2],2'b00}+4*cause_in; otherwise {mtvec[31:2],2'b00}.
REQ-020 SHALL increment 64-bit mcycle every cycle and 64-bit minstret when instret_inc_in=1, with carry from low to high word; all-ones wraps to 0.
REQ-021 SHALL, when software writes either counter half, commit the written value and apply no increment to that counter that cycle.

Reset
REQ-022 SHALL, on rst_in, asynchronously clear mstatus MIE and MPIE, mie, mip, mepc, mcause, mtval, mscratch, mcycle and minstret to 0, and set mtvec to RESET_MTVEC.
REQ-023 SHALL hold all outputs at values derived from these reset values while in reset, including trap_address_out=RESET_MTVEC and epc_out=0.
REQ-024 SHALL abandon any write in flight when reset is asserted mid-cycle.

Structure
REQ-025 SHALL take CSR address constants, csr_op encodings, the misa value and the bit positions for MIE, MPIE, MEIE, MTIE and MSIE from a shared package.
REQ-026 SHALL implement each 64-bit counter as an instance of sub-module csr_counter_64, which has inc, wr_lo, wr_hi and wdata inputs.

Verification
REQ-027 SHALL cover: reset, then read 0x305 -> RESET_MTVEC; read 0xF14 -> MHARTID; read 0x300 -> 32'h0000_1800.
REQ-028 SHALL cover: RW 0x340 with 32'hDEAD_BEEF, then RC with 32'h0000_00FF -> reads 32'hDEAD_BE00; RS with wdata 0 -> no change.
REQ-029 SHALL cover: with MIE=1, pc_in=32'h0000_0103, cause 4, misaligned=1, iadder=32'h0000_2001, set_cause/set_epc/mie_clear pulsed -> mepc=32'h0000_0100, mcause=4, mtval=32'h0000_2001, MIE=0, MPIE=1; then mie_set -> MIE=1.
REQ-030 SHALL cover: mtvec=32'h0000_1001, i_or_e=1, cause=11 -> trap_address_out=32'h0000_102C; with i_or_e=0 -> 32'h0000_1000.
REQ-031 SHALL cover: write mcycle=32'hFFFF_FFFF and mcycleh=32'hFFFF_FFFF, wait 1 cycle -> both read 0; same-cycle trap update and RW to mepc -> trap value kept.
